// File: rtl/bcd_counter_pkg.sv
// bcd_counter_pkg: shared constants, shift FSM states and seven-segment decoder.
// BCC_SEVENSEG_EN selects an 8-bit segment frame per digit instead of the raw nibble.
package bcd_counter_pkg;
  localparam logic [3:0] BCD_MAX = 4'd9;
`ifdef BCC_SEVENSEG_EN
  localparam int SEG_W = 8;
`else
  localparam int SEG_W = 4;
`endif
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} shift_state_e;
  // segments {dp,g,f,e,d,c,b,a}, active high; non-BCD codes blank the digit
  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 8'h3f;
      4'd1: return 8'h06;
      4'd2: return 8'h5b;
      4'd3: return 8'h4f;
      4'd4: return 8'h66;
      4'd5: return 8'h6d;
      4'd6: return 8'h7d;
      4'd7: return 8'h07;
      4'd8: return 8'h7f;
      4'd9: return 8'h6f;
      default: return 8'h00;
    endcase
  endfunction
endpackage

// File: rtl/bcd_counter_core_if.sv
// bcd_counter_core_if: step/control inputs and count/display outputs of bcd_counter_core.
interface bcd_counter_core_if #(parameter int DIGITS = 4);
  logic [DIGITS-1:0] inc_req;
  logic up_dn, carry_en, limit_en, limit_load;
  logic [4*DIGITS-1:0] count;
  logic ovf, seg_data, seg_clk, seg_latch, busy;
  modport master(output inc_req, up_dn, carry_en, limit_en, limit_load,
                 input count, ovf, seg_data, seg_clk, seg_latch, busy);
  modport slave(input inc_req, up_dn, carry_en, limit_en, limit_load,
                output count, ovf, seg_data, seg_clk, seg_latch, busy);
endinterface

// File: rtl/bcd_seg_shifter.sv
// bcd_seg_shifter: snapshots the count and shifts it out MSB-first with clock and latch strobe.
// BCC_SEVENSEG_EN sends decoded segments per digit, otherwise the raw BCD nibble.
module bcd_seg_shifter
  import bcd_counter_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SHIFT_DIV = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DIGITS-1:0][3:0] count_i,
  input  logic                   upd_i,
  output logic                   seg_data_o,
  output logic                   seg_clk_o,
  output logic                   seg_latch_o,
  output logic                   busy_o
);
  localparam int NB = DIGITS * SEG_W;
  localparam int DW = $clog2(SHIFT_DIV + 1);
  localparam int BW = $clog2(NB);
  shift_state_e state_q;
  logic refresh_q, seg_data_q, seg_clk_q, seg_latch_q, busy_q, tick;
  logic [NB-1:0] frame, sh_q;
  logic [DW-1:0] div_q;
  logic [BW-1:0] bit_q;
  always_comb begin
    frame = '0;
    for (int k = 0; k < DIGITS; k++)
`ifdef BCC_SEVENSEG_EN
      frame[k*SEG_W +: SEG_W] = seg7(count_i[k]);
`else
      frame[k*SEG_W +: SEG_W] = count_i[k];
`endif
  end
  assign tick = div_q == DW'(SHIFT_DIV - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      refresh_q   <= 1'b1;
      sh_q        <= '0;
      div_q       <= '0;
      bit_q       <= '0;
      seg_data_q  <= 1'b0;
      seg_clk_q   <= 1'b0;
      seg_latch_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      refresh_q <= upd_i | (refresh_q & (state_q != IDLE));
      div_q     <= (state_q == IDLE || tick) ? '0 : div_q + 1'b1;
      case (state_q)
        IDLE: if (refresh_q) begin
          state_q    <= SHIFT;
          sh_q       <= frame;
          seg_data_q <= frame[NB-1];
          bit_q      <= '0;
          busy_q     <= 1'b1;
        end
        SHIFT: if (tick) begin
          seg_clk_q <= ~seg_clk_q;
          // data only moves on the falling edge of seg_clk
          if (seg_clk_q) begin
            if (bit_q == BW'(NB - 1)) begin
              state_q     <= LATCH;
              seg_latch_q <= 1'b1;
            end else begin
              bit_q      <= bit_q + 1'b1;
              sh_q       <= sh_q << 1;
              seg_data_q <= sh_q[NB-2];
            end
          end
        end
        LATCH: if (tick) begin
          state_q     <= IDLE;
          seg_latch_q <= 1'b0;
          busy_q      <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign seg_data_o  = seg_data_q;
  assign seg_clk_o   = seg_clk_q;
  assign seg_latch_o = seg_latch_q;
  assign busy_o      = busy_q;
endmodule

// File: rtl/bcd_counter_core.sv
// bcd_counter_core: debounced per-digit step requests, BCD up/down ripple with limits, display shift-out.
// BCC_SEVENSEG_EN (in the shifter) switches the frame to seven-segment codes.
module bcd_counter_core
  import bcd_counter_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int LOCKOUT_CYC = 1000,
  parameter int SHIFT_DIV   = 4
) (
  input logic clk,
  input logic rst_n,
  bcd_counter_core_if.slave bus
);
  localparam int LW = $clog2(LOCKOUT_CYC + 1);
  logic [DIGITS-1:0] req_q, req2_q, rise, accept, pend_q, pend_d, grant, act, wrap;
  logic [DIGITS-1:0][LW-1:0] lock_q, lock_d;
  logic [DIGITS-1:0][3:0] cnt_q, cnt_d, lim_q, lim_eff;
  logic [DIGITS:0] c;
  logic ovf_q, ovf_d, upd;
  assign rise = req_q & ~req2_q;
  always_comb begin
    grant = pend_q & (~pend_q + 1'b1);
    c = '0;
    // c[j] is the carry/borrow rippling into digit j within this cycle
    for (int j = 0; j < DIGITS; j++) begin
      accept[j]  = rise[j] && lock_q[j] == '0;
      lock_d[j]  = accept[j] ? LW'(LOCKOUT_CYC - 1) : lock_q[j] - LW'(lock_q[j] != '0);
      lim_eff[j] = bus.limit_en && lim_q[j] < BCD_MAX ? lim_q[j] : BCD_MAX;
      act[j]     = grant[j] | c[j];
      wrap[j]    = bus.up_dn ? cnt_q[j] >= lim_eff[j] : cnt_q[j] == 4'd0;
      cnt_d[j]   = !act[j] ? cnt_q[j] : wrap[j] ? (bus.up_dn ? 4'd0 : lim_eff[j]) :
                   bus.up_dn ? cnt_q[j] + 4'd1 : cnt_q[j] - 4'd1;
      c[j+1]     = act[j] & wrap[j] & bus.carry_en;
    end
    pend_d = (pend_q & ~grant) | accept;
    ovf_d  = bus.limit_load ? 1'b0 : ovf_q | c[DIGITS];
  end
  assign upd = cnt_d != cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q  <= '0;
      req2_q <= '0;
      pend_q <= '0;
      lock_q <= '0;
      cnt_q  <= '0;
      lim_q  <= {DIGITS{BCD_MAX}};
      ovf_q  <= 1'b0;
    end else begin
      req_q  <= bus.inc_req;
      req2_q <= req_q;
      pend_q <= pend_d;
      lock_q <= lock_d;
      cnt_q  <= cnt_d;
      lim_q  <= bus.limit_load ? cnt_q : lim_q;
      ovf_q  <= ovf_d;
    end
  end
  assign bus.count = cnt_q;
  assign bus.ovf   = ovf_q;
  bcd_seg_shifter #(.DIGITS(DIGITS), .SHIFT_DIV(SHIFT_DIV)) u_shift (
    .clk        (clk),
    .rst_n      (rst_n),
    .count_i    (cnt_q),
    .upd_i      (upd),
    .seg_data_o (bus.seg_data),
    .seg_clk_o  (bus.seg_clk),
    .seg_latch_o(bus.seg_latch),
    .busy_o     (bus.busy)
  );
endmodule

// File: tb/tb_bcd_counter_core.sv
// tb_bcd_counter_core: directed vectors for stepping, ripple, limits, lockout and display frames.
// Expected frames follow BCC_SEVENSEG_EN the same way the design does.
module tb_bcd_counter_core;
  localparam int D = 2, LOCK = 8, DIV = 1;
`ifdef BCC_SEVENSEG_EN
  localparam int W = 8;
`else
  localparam int W = 4;
`endif
  logic clk = 1'b0, rst_n = 1'b0, last_data = 1'b0;
  logic [15:0] cap = '0;
  int n_chk = 0, n_pass = 0, nbits = 0, lat_cyc = 0, viol = 0;
  bcd_counter_core_if #(.DIGITS(D)) bus();
  bcd_counter_core #(.DIGITS(D), .LOCKOUT_CYC(LOCK), .SHIFT_DIV(DIV)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  always @(posedge bus.busy) begin
    nbits = 0;
    cap = '0;
    lat_cyc = 0;
  end
  always @(posedge bus.seg_clk) begin
    nbits++;
    cap = {cap[14:0], bus.seg_data};
  end
  always @(negedge clk) begin
    if (bus.seg_latch) lat_cyc++;
    if (bus.seg_data !== last_data && bus.seg_clk) viol++;
    last_data = bus.seg_data;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [7:0] seg(input logic [3:0] d);
    case (d)
      4'd0: return 8'h3f;
      4'd1: return 8'h06;
      4'd2: return 8'h5b;
      4'd3: return 8'h4f;
      4'd4: return 8'h66;
      4'd5: return 8'h6d;
      4'd6: return 8'h7d;
      4'd7: return 8'h07;
      4'd8: return 8'h7f;
      4'd9: return 8'h6f;
      default: return 8'h00;
    endcase
  endfunction
  function automatic logic [15:0] frame_of(input logic [7:0] v);
`ifdef BCC_SEVENSEG_EN
    return {seg(v[7:4]), seg(v[3:0])};
`else
    return {8'h00, v};
`endif
  endfunction
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse(input logic [D-1:0] m, input logic up);
    bus.up_dn = up;
    bus.inc_req = m;
    cyc(1);
    bus.inc_req = '0;
  endtask
  task automatic step(input int j, input logic up);
    pulse(D'(1) << j, up);
    cyc(40);
  endtask
  task automatic load_limit();
    bus.limit_load = 1'b1;
    cyc(1);
    bus.limit_load = 1'b0;
  endtask
  task automatic wait_idle();
    int quiet = 0, t = 0;
    while (quiet < 3 && t < 500) begin
      cyc(1);
      t++;
      quiet = bus.busy ? 0 : quiet + 1;
    end
    if (quiet < 3) chk("idle timeout", t, 0);
  endtask
  task automatic chk_frame(input string tag, input logic [7:0] v);
    wait_idle();
    chk({tag, " bits"}, cap, frame_of(v));
    chk({tag, " len"}, nbits, D * W);
    chk({tag, " latch"}, lat_cyc, DIV);
    chk({tag, " busy low"}, bus.busy, 0);
  endtask
  initial begin
    logic [7:0] wrap_seq [4] = '{8'h01, 8'h02, 8'h03, 8'h10};
    int t;
    bus.inc_req = '0;
    bus.up_dn = 1'b1;
    bus.carry_en = 1'b1;
    bus.limit_en = 1'b0;
    bus.limit_load = 1'b0;
    cyc(3);
    chk("reset count", bus.count, 0);
    chk("reset flags", {bus.ovf, bus.seg_data, bus.seg_clk, bus.seg_latch, bus.busy}, 0);
    rst_n = 1'b1;
    chk_frame("boot frame", 8'h00);
    // step latency: edge sampled at n, count moves at n+2
    pulse(2'b01, 1'b1);
    cyc(1);
    chk("latency n+1", bus.count, 8'h00);
    cyc(1);
    chk("latency n+2", bus.count, 8'h01);
    cyc(40);
    for (int i = 1; i < 10; i++) begin
      step(0, 1'b1);
      if (i == 8) chk("nine ups", bus.count, 8'h09);
    end
    chk("ten ups", bus.count, 8'h10);
    chk("ten ups ovf", bus.ovf, 0);
    chk_frame("frame 10", 8'h10);
    chk("data stable", viol, 0);
    step(1, 1'b0);
    chk("down d1", bus.count, 8'h00);
    step(0, 1'b0);
    chk("borrow 99", bus.count, 8'h99);
    chk("borrow ovf", bus.ovf, 1);
    load_limit();
    chk("load clr ovf", bus.ovf, 0);
    step(0, 1'b1);
    chk("carry 00", bus.count, 8'h00);
    step(1, 1'b1);
    step(1, 1'b1);
    for (int i = 0; i < 3; i++) step(0, 1'b1);
    chk("set 23", bus.count, 8'h23);
    load_limit();
    bus.limit_en = 1'b1;
    step(0, 1'b1);
    chk("limit wrap 00", bus.count, 8'h00);
    chk("limit wrap ovf", bus.ovf, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 1'b1);
      chk("limit seq", bus.count, 32'(wrap_seq[i]));
    end
    step(0, 1'b0);
    chk("limit borrow", bus.count, 8'h03);
    bus.limit_en = 1'b0;
    for (int i = 0; i < 3; i++) step(0, 1'b0);
    chk("back to 00", bus.count, 8'h00);
    pulse(2'b11, 1'b1);
    cyc(1);
    chk("simul n+1", bus.count, 8'h00);
    cyc(1);
    chk("simul n+2", bus.count, 8'h01);
    cyc(1);
    chk("simul n+3", bus.count, 8'h11);
    pulse(2'b01, 1'b1);
    cyc(12);
    chk("lockout drop", bus.count, 8'h11);
    step(0, 1'b1);
    chk("after lockout", bus.count, 8'h12);
    // abort a frame mid-shift with reset
    pulse(2'b01, 1'b1);
    t = 0;
    while (!bus.busy && t < 20) begin
      cyc(1);
      t++;
    end
    chk("frame start", bus.busy, 1);
    cyc(6);
    rst_n = 1'b0;
    cyc(1);
    chk("midreset count", bus.count, 0);
    chk("midreset flags", {bus.ovf, bus.seg_data, bus.seg_clk, bus.seg_latch, bus.busy}, 0);
    rst_n = 1'b1;
    chk_frame("post reset frame", 8'h00);
    chk("data stable end", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bcd_counter_core.md
# bcd_counter_core

Parametrised multi-digit BCD up/down counter with per-digit step inputs, decimal carry/borrow ripple, a loadable per-digit limit and a serial display shift-out engine. It is the next generation of the team's top-level counter datapath: digit count is configurable, simultaneous step requests are queued instead of lost, and the serial output has an explicit latch strobe. It sits between the input synchronizers and the external shift-register display chain.

## Interface
- DIGITS, 4: number of BCD digits, 2..8.
- LOCKOUT_CYC, 1000: cycles a channel ignores new rising edges after one is accepted (debounce), >= 1.
- SHIFT_DIV, 4: system cycles per seg_clk half-period, >= 1.
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous and active-low.
- inc_req  in  DIGITS  per-digit step request, level, active high, already synchronized to clk.
- up_dn  in  1  1 = count up, 0 = count down; sampled when a step is applied.
- carry_en  in  1  enables carry/borrow ripple into higher digits.
- limit_en  in  1  per-digit wrap uses the limit register instead of 9.
- limit_load  in  1  single-cycle pulse: limit register <= count, ovf cleared.
- count  out  4*DIGITS  current count, digit j at [4j+3:4j].
- ovf  out  1  sticky: carry/borrow left digit DIGITS-1.
- seg_data  out  1  serial display data.
- seg_clk  out  1  serial display clock.
- seg_latch  out  1  display latch strobe.
- busy  out  1  shift frame in progress.

## Operation
- Per channel: rising-edge detector on inc_req[j]; an edge arriving while channel j is in lockout is dropped; otherwise pending[j] is set and the channel enters lockout for LOCKOUT_CYC cycles.
- Arbiter: each cycle the lowest-index set pending bit is serviced and cleared; one step per cycle.
- Effective limit L_j = limit_en ? min(limit_j, 9) : 9.
- Up step on digit j: if digit >= L_j, then digit <= 0 and carry to j+1 (when carry_en); else digit + 1.
- Down step: if digit == 0, then digit <= L_j and borrow to j+1 (when carry_en); else digit - 1.
- Ripple is combinational within the servicing cycle. Carry/borrow out of the top digit is discarded and sets ovf.
- limit_load in the same cycle as a step: the limit captures the pre-step count.
- Shift engine FSM IDLE -> SHIFT -> LATCH -> IDLE.
  - Any change of count sets refresh_pending. In IDLE with refresh_pending set, it snapshots count, clears refresh_pending and enters SHIFT.
  - SHIFT: DIGITS*W bits, most-significant digit first, MSB first within each digit.
  - LATCH: seg_latch high for SHIFT_DIV cycles, then back to IDLE.
- Count changes during a frame do not alter the frame; they leave refresh_pending set.
- refresh_pending is set by reset release, so the first frame displays all zeros.

## Timing
- Reset values: count 0, limit all 9, ovf 0, pending 0, lockout 0, seg_data/seg_clk/seg_latch/busy 0, FSM IDLE, refresh_pending 1.
- A reset asserted mid-frame aborts the frame in the same edge.
- Step latency: an inc_req rising edge sampled at edge n updates count at edge n+2 if it is the only pending request. Each higher-priority pending request adds 1 cycle.
- Lockout: the next edge on the same channel is accepted only once LOCKOUT_CYC cycles have elapsed after the accepting edge.
- Frame timing:
  - busy rises 1 cycle after refresh_pending is seen in IDLE.
  - seg_data changes only while seg_clk is low and is held for SHIFT_DIV cycles before the seg_clk rise.
  - Each bit occupies 2*SHIFT_DIV cycles. seg_latch follows the final seg_clk fall.
  - busy falls with seg_latch.
  - The next frame may start on the following cycle.

## Configuration
- BCC_SEVENSEG_EN defined: W = 8; each digit is sent as segments {dp=0,g,f,e,d,c,b,a}, active high.
- BCC_SEVENSEG_EN undefined: W = 4; the raw BCD nibble is sent and no decoder is synthesized.

## Structure
- Package bcd_counter_pkg:
  - BCD_MAX = 4'd9.
  - Shift FSM state enum.
  - Seven-segment decode function; codes 10..15 decode to all-off.
- Sub-module bcd_seg_shifter: snapshot register, bit/digit counters, clock divider and FSM.
- bcd_counter_core holds the edge detectors, lockout counters, arbiter, digit/limit registers and ovf.

## Test plan
- Single digit: DIGITS=2, up, carry_en=1, ten edges on inc_req[0] spaced > LOCKOUT_CYC. Expected: count=8'h10 and ovf=0.
- Down from 00 with carry_en=1 and one edge on inc_req[0]. Expected: count=8'h99 and ovf=1. Then pulse limit_load. Expected: ovf=0 and limit=99.
- Limit wrap: set count=8'h23, pulse limit_load, limit_en=1, reset count via steps to 00, step digit0 up four times. Expected: digit0 goes 1,2,3,0 and carry makes count=8'h10.
- Simultaneous edges on inc_req[1:0] in one cycle from 00, up. Expected: count=8'h01 at n+2 and 8'h11 at n+3. Then a second edge within lockout. Expected: ignored.
- Frame: BCC_SEVENSEG_EN defined, DIGITS=2, count=8'h10, SHIFT_DIV=1. Expected: 16 seg_clk rises capturing 8'h06, 8'h3F, then one seg_latch pulse, busy low after.
- Reset mid-frame: rst_n=0 during SHIFT. Expected: next edge has all outputs 0 and a zero frame after release.
